// File: rtl/mux_tree_pipe_pkg.sv
// Shared constants and elaboration helpers for the pipelined N:1 mux tree.
package mux_tree_pipe_pkg;

    localparam int TAG_W = 8;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // One pipeline stage per pair of select bits.
    function automatic int n_levels(input int sel_w);
        return (sel_w + 1) / 2;
    endfunction

    // Words entering stage k; k = LEVELS yields the single output word.
    function automatic int words_at(input int n, input int k);
        int w;
        w = n;
        for (int i = 0; i < k; i++) w = (w + 3) / 4;
        return w;
    endfunction

    function automatic int link_off(input int n, input int k);
        int off;
        off = 0;
        for (int i = 0; i < k; i++) off += words_at(n, i);
        return off;
    endfunction

endpackage

// File: rtl/mux_tree_pipe_stage.sv
// One tree level: FANIN:1 selects over groups of input words, then the stage
// register with its valid/ready handshake.
module mux_tree_pipe_stage
    import mux_tree_pipe_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int N_WORDS = 32,
    parameter int FANIN   = 4,
    parameter int SEL_W   = 5
) (
    input  logic                                         clock,
    input  logic                                         reset,
    input  logic                                         i_valid,
    output logic                                         o_ready,
    input  logic [N_WORDS*WIDTH-1:0]                     i_data,
    input  logic [SEL_W-1:0]                             i_sel,
    input  logic [TAG_W-1:0]                             i_tag,
    input  logic                                         i_oob,
    output logic                                         o_valid,
    input  logic                                         i_ready,
    output logic [((N_WORDS+FANIN-1)/FANIN)*WIDTH-1:0]   o_data,
    output logic [SEL_W-1:0]                             o_sel,
    output logic [TAG_W-1:0]                             o_tag,
    output logic                                         o_oob
);
    localparam int SHIFT = (FANIN == 4) ? 2 : 1;
    localparam int N_OUT = (N_WORDS + FANIN - 1) / FANIN;
    localparam int PAD_W = N_OUT * FANIN * WIDTH;

    logic [PAD_W-1:0]       w_pad;
    logic [SHIFT-1:0]       w_lsel;
    logic [N_OUT*WIDTH-1:0] w_next;
    logic                   w_en;

    logic                   r_valid;
    logic [N_OUT*WIDTH-1:0] r_data;
    logic [SEL_W-1:0]       r_sel;
    logic [TAG_W-1:0]       r_tag;
    logic                   r_oob;

    // Zero-extend so missing slots of the last group read as 0.
    assign w_pad  = PAD_W'(i_data);
    assign w_lsel = i_sel[SHIFT-1:0];

    for (genvar j = 0; j < N_OUT; j++) begin : g_grp
        assign w_next[j*WIDTH +: WIDTH] = w_pad[(j*FANIN + int'(w_lsel))*WIDTH +: WIDTH];
    end

    assign w_en    = !r_valid || i_ready;
    assign o_ready = w_en;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_tag   <= '0;
            r_oob   <= 1'b0;
        end else if (w_en) begin
            r_valid <= i_valid;
            if (i_valid) begin
                r_data <= w_next;
                r_sel  <= i_sel >> SHIFT;
                r_tag  <= i_tag;
                r_oob  <= i_oob;
            end
        end
    end

    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_sel   = r_sel;
    assign o_tag   = r_tag;
    assign o_oob   = r_oob;

endmodule

// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 word selector: a chain of registered 4:1 tree levels (2:1 for
// an odd leftover select bit) with valid/ready backpressure.
module mux_tree_pipe
    import mux_tree_pipe_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int N_IN   = 32,
    // Derived; leave at default.
    parameter int SEL_W  = clog2(N_IN),
    parameter int LEVELS = n_levels(SEL_W)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]      in_sel,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      out_data,
    output logic [TAG_W-1:0]      out_tag,
    output logic                  out_oob
);
    localparam int LINK_W = (link_off(N_IN, LEVELS) + 1) * WIDTH;

    // Link k feeds stage k; link 0 is the input bus, link LEVELS the output word.
    logic [LINK_W-1:0]          w_link;
    logic [LEVELS:0]            w_valid;
    logic [LEVELS:0]            w_ready;
    logic [LEVELS:0]            w_oob;
    logic [LEVELS:0][SEL_W-1:0] w_sel;
    logic [LEVELS:0][TAG_W-1:0] w_tag;
    logic                       w_unused_sel;

    assign w_link[N_IN*WIDTH-1:0] = in_data;
    assign w_valid[0]      = in_valid;
    assign w_sel[0]        = in_sel;
    assign w_tag[0]        = in_tag;
    assign w_ready[LEVELS] = out_ready;
    assign in_ready        = w_ready[0];

    if (N_IN == (1 << SEL_W)) begin : g_no_oob
        assign w_oob[0] = 1'b0;
    end else begin : g_oob
        assign w_oob[0] = (in_sel >= SEL_W'(N_IN));
    end

    for (genvar k = 0; k < LEVELS; k++) begin : g_lvl
        localparam int NI  = words_at(N_IN, k);
        localparam int FI  = (2 * k + 1 == SEL_W) ? 2 : 4;
        localparam int NO  = (NI + FI - 1) / FI;
        localparam int OFI = link_off(N_IN, k) * WIDTH;
        localparam int OFO = OFI + NI * WIDTH;

        mux_tree_pipe_stage #(
            .WIDTH   (WIDTH),
            .N_WORDS (NI),
            .FANIN   (FI),
            .SEL_W   (SEL_W)
        ) u_stage (
            .clock   (clock),
            .reset   (reset),
            .i_valid (w_valid[k]),
            .o_ready (w_ready[k]),
            .i_data  (w_link[OFI +: NI*WIDTH]),
            .i_sel   (w_sel[k]),
            .i_tag   (w_tag[k]),
            .i_oob   (w_oob[k]),
            .o_valid (w_valid[k+1]),
            .i_ready (w_ready[k+1]),
            .o_data  (w_link[OFO +: NO*WIDTH]),
            .o_sel   (w_sel[k+1]),
            .o_tag   (w_tag[k+1]),
            .o_oob   (w_oob[k+1])
        );
    end

    assign out_valid    = w_valid[LEVELS];
    assign out_data     = w_link[LINK_W-WIDTH +: WIDTH];
    assign out_tag      = w_tag[LEVELS];
    assign out_oob      = w_oob[LEVELS];
    assign w_unused_sel = ^w_sel[LEVELS];

endmodule

// File: tb/tb_mux_tree_pipe.sv
// Bench for mux_tree_pipe: three configurations (32x32, 5x8, 13x16) with
// per-instance scoreboards plus directed latency, stall and reset sequences.
module tb_mux_tree_pipe;

    typedef struct packed {
        logic [31:0] data;
        logic [7:0]  tag;
        logic        oob;
    } exp_t;

    typedef struct {
        logic [7:0]  sel;
        logic [7:0]  tag;
        logic [31:0] data;
        logic        oob;
    } vec_t;

    int n_tests = 0;
    int n_fail  = 0;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_oob;
    logic [32*32-1:0] a_in_data;
    logic [4:0] a_in_sel;
    logic [7:0] a_in_tag, a_out_tag;
    logic [31:0] a_out_data;

    logic b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_oob;
    logic [5*8-1:0] b_in_data;
    logic [2:0] b_in_sel;
    logic [7:0] b_in_tag, b_out_tag;
    logic [7:0] b_out_data;

    logic c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_oob;
    logic [13*16-1:0] c_in_data;
    logic [3:0] c_in_sel;
    logic [7:0] c_in_tag, c_out_tag;
    logic [15:0] c_out_data;

    mux_tree_pipe #(.WIDTH(32), .N_IN(32)) u_a (
        .clock(clock), .reset(reset), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_data(a_in_data), .in_sel(a_in_sel), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .out_tag(a_out_tag), .out_oob(a_out_oob));

    mux_tree_pipe #(.WIDTH(8), .N_IN(5)) u_b (
        .clock(clock), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .in_sel(b_in_sel), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_tag(b_out_tag), .out_oob(b_out_oob));

    mux_tree_pipe #(.WIDTH(16), .N_IN(13)) u_c (
        .clock(clock), .reset(reset), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .in_data(c_in_data), .in_sel(c_in_sel), .in_tag(c_in_tag),
        .out_valid(c_out_valid), .out_ready(c_out_ready), .out_data(c_out_data),
        .out_tag(c_out_tag), .out_oob(c_out_oob));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] b_model(input logic [2:0] s);
        return (s < 3'd5) ? 8'h11 * (8'(s) + 8'd1) : 8'h00;
    endfunction

    exp_t qa[$], qb[$], qc[$];
    exp_t ea, eb, ec;

    // Scoreboards: push on accepted requests, pop on delivered results.
    always @(negedge clock) begin
        if (reset) begin
            qa.delete(); qb.delete(); qc.delete();
        end else begin
            if (a_in_valid && a_in_ready)
                qa.push_back('{data: 32'hA000_0000 + 32'(a_in_sel), tag: a_in_tag, oob: 1'b0});
            if (b_in_valid && b_in_ready)
                qb.push_back('{data: 32'(b_model(b_in_sel)), tag: b_in_tag, oob: (b_in_sel >= 3'd5)});
            if (c_in_valid && c_in_ready)
                qc.push_back('{data: (c_in_sel < 4'd13) ? 32'(c_in_data[int'(c_in_sel)*16 +: 16]) : 32'h0,
                               tag: c_in_tag, oob: (c_in_sel >= 4'd13)});
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) chk("a_unexpected_out", 64'(1), 64'(0));
                else begin
                    ea = qa.pop_front();
                    chk("a_sb_data", 64'(a_out_data), 64'(ea.data));
                    chk("a_sb_tag", 64'(a_out_tag), 64'(ea.tag));
                    chk("a_sb_oob", 64'(a_out_oob), 64'(ea.oob));
                end
            end
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) chk("b_unexpected_out", 64'(1), 64'(0));
                else begin
                    eb = qb.pop_front();
                    chk("b_sb_data", 64'(b_out_data), 64'(eb.data));
                    chk("b_sb_tag", 64'(b_out_tag), 64'(eb.tag));
                    chk("b_sb_oob", 64'(b_out_oob), 64'(eb.oob));
                end
            end
            if (c_out_valid && c_out_ready) begin
                if (qc.size() == 0) chk("c_unexpected_out", 64'(1), 64'(0));
                else begin
                    ec = qc.pop_front();
                    chk("c_sb_data", 64'(c_out_data), 64'(ec.data));
                    chk("c_sb_tag", 64'(c_out_tag), 64'(ec.tag));
                    chk("c_sb_oob", 64'(c_out_oob), 64'(ec.oob));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t va[4];
    vec_t vb[6];
    int   acc;

    initial begin
        va[0] = '{8'd0,  8'd1, 32'hA000_0000, 1'b0};
        va[1] = '{8'd31, 8'd2, 32'hA000_001F, 1'b0};
        va[2] = '{8'd17, 8'd3, 32'hA000_0011, 1'b0};
        va[3] = '{8'd5,  8'd4, 32'hA000_0005, 1'b0};
        vb[0] = '{8'd4, 8'h21, 32'h55, 1'b0};
        vb[1] = '{8'd6, 8'h22, 32'h00, 1'b1};
        vb[2] = '{8'd0, 8'h23, 32'h11, 1'b0};
        vb[3] = '{8'd2, 8'h24, 32'h33, 1'b0};
        vb[4] = '{8'd7, 8'h25, 32'h00, 1'b1};
        vb[5] = '{8'd1, 8'h26, 32'h22, 1'b0};

        for (int i = 0; i < 32; i++) a_in_data[i*32 +: 32] = 32'hA000_0000 + 32'(i);
        for (int i = 0; i < 5; i++)  b_in_data[i*8 +: 8] = 8'h11 * 8'(i + 1);
        c_in_data = '0;
        a_in_valid = 0; a_in_sel = '0; a_in_tag = '0; a_out_ready = 1;
        b_in_valid = 0; b_in_sel = '0; b_in_tag = '0; b_out_ready = 1;
        c_in_valid = 0; c_in_sel = '0; c_in_tag = '0; c_out_ready = 1;

        repeat (2) @(posedge clock);
        #1 reset = 0;
        chk("rst_a_out_valid", 64'(a_out_valid), 64'(0));
        chk("rst_a_out_data", 64'(a_out_data), 64'(0));
        chk("rst_a_out_tag", 64'(a_out_tag), 64'(0));
        chk("rst_a_out_oob", 64'(a_out_oob), 64'(0));
        chk("rst_a_in_ready", 64'(a_in_ready), 64'(1));
        chk("rst_b_out_valid", 64'(b_out_valid), 64'(0));
        chk("rst_c_in_ready", 64'(c_in_ready), 64'(1));

        // 32x32 back-to-back stream: latency 3, then one result per cycle.
        for (int i = 0; i < 7; i++) begin
            a_in_valid = (i < 4);
            if (i < 4) begin a_in_sel = va[i].sel[4:0]; a_in_tag = va[i].tag; end
            if (i >= 3) begin
                chk("a_stream_valid", 64'(a_out_valid), 64'(1));
                chk("a_stream_data", 64'(a_out_data), 64'(va[i-3].data));
                chk("a_stream_tag", 64'(a_out_tag), 64'(va[i-3].tag));
                chk("a_stream_oob", 64'(a_out_oob), 64'(va[i-3].oob));
            end else chk("a_latency_idle", 64'(a_out_valid), 64'(0));
            @(posedge clock); #1;
        end
        chk("a_stream_end", 64'(a_out_valid), 64'(0));

        // 5x8: padded slots and out-of-range selects, latency 2.
        for (int i = 0; i < 8; i++) begin
            b_in_valid = (i < 6);
            if (i < 6) begin b_in_sel = vb[i].sel[2:0]; b_in_tag = vb[i].tag; end
            if (i >= 2) begin
                chk("b_vec_valid", 64'(b_out_valid), 64'(1));
                chk("b_vec_data", 64'(b_out_data), 64'(vb[i-2].data));
                chk("b_vec_tag", 64'(b_out_tag), 64'(vb[i-2].tag));
                chk("b_vec_oob", 64'(b_out_oob), 64'(vb[i-2].oob));
            end else chk("b_latency_idle", 64'(b_out_valid), 64'(0));
            @(posedge clock); #1;
        end
        b_in_valid = 0;

        // Backpressure: only LEVELS requests fit, output holds while stalled.
        a_out_ready = 0; a_in_valid = 1; acc = 0;
        for (int i = 0; i < 6; i++) begin
            a_in_sel = 5'(8 + i); a_in_tag = 8'(10 + i);
            @(negedge clock);
            if (a_in_ready) acc++;
            @(posedge clock); #1;
        end
        chk("bp_accepted", 64'(acc), 64'(3));
        chk("bp_in_ready", 64'(a_in_ready), 64'(0));
        chk("bp_out_valid", 64'(a_out_valid), 64'(1));
        chk("bp_hold_data", 64'(a_out_data), 64'(32'hA000_0008));
        @(posedge clock); #1;
        chk("bp_hold_data2", 64'(a_out_data), 64'(32'hA000_0008));
        chk("bp_hold_tag", 64'(a_out_tag), 64'(10));
        a_in_valid = 0; a_out_ready = 1;
        #1 chk("bp_release_ready", 64'(a_in_ready), 64'(1));
        for (int i = 0; i < 20 && qa.size() != 0; i++) @(posedge clock);
        #1 chk("bp_drain", 64'(qa.size()), 64'(0));

        // Reset with three requests in flight: nothing may emerge afterwards.
        @(posedge clock); #1;
        a_out_ready = 0; a_in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            a_in_sel = 5'(20 + i); a_in_tag = 8'(40 + i);
            @(posedge clock); #1;
        end
        a_in_valid = 0; reset = 1;
        @(posedge clock); #1 reset = 0;
        chk("mid_rst_out_valid", 64'(a_out_valid), 64'(0));
        chk("mid_rst_out_data", 64'(a_out_data), 64'(0));
        chk("mid_rst_in_ready", 64'(a_in_ready), 64'(1));
        a_out_ready = 1;
        for (int i = 0; i < 6; i++) begin
            @(posedge clock); #1;
            chk("mid_rst_no_stale", 64'(a_out_valid), 64'(0));
        end

        // 13x16 random traffic against the scoreboard.
        for (int cyc = 0; cyc < 10000; cyc++) begin
            c_in_valid  = ($urandom_range(0, 3) != 0);
            c_out_ready = ($urandom_range(0, 3) != 0);
            c_in_sel    = 4'($urandom_range(0, 15));
            c_in_tag    = 8'($urandom);
            for (int w = 0; w < 13; w++) c_in_data[w*16 +: 16] = 16'($urandom);
            @(posedge clock); #1;
        end
        c_in_valid = 0; c_out_ready = 1;
        for (int i = 0; i < 20 && qc.size() != 0; i++) @(posedge clock);
        #1 chk("c_drain", 64'(qc.size()), 64'(0));
        chk("b_drain", 64'(qb.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
